imm_gen_stage: RTL

Registered, handshaked immediate generator for the decode stage of the ARES RISC-V core. It replaces the purely combinational immediate decode with a one-stage pipeline. The stage has a valid/ready interface, a two-entry skid buffer and a flush input, so decode back-pressure does not form a combinational path back to fetch. XLEN is parametrised so the same block serves RV32 and RV64 builds.

---
 rtl/imm_gen_stage_pkg.sv | 25 ++
 rtl/imm_gen_stage_decode.sv | 50 +++++
 rtl/imm_gen_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/imm_gen_stage_pkg.sv
// -----------------------------------------------------------------------------
// core_param
// Purpose : shared constants for the ARES decode stage.
//           - IMMSEL_* : immediate format select encodings driven by the decoder
//           - skid_state_t : occupancy states of the immediate generator's
//             two-entry skid buffer
// Ports   : none (package)
// -----------------------------------------------------------------------------
package core_param;

    localparam logic [2:0] IMMSEL_I = 3'd0;
    localparam logic [2:0] IMMSEL_S = 3'd1;
    localparam logic [2:0] IMMSEL_B = 3'd2;
    localparam logic [2:0] IMMSEL_J = 3'd3;
    localparam logic [2:0] IMMSEL_U = 3'd4;
    localparam logic [2:0] IMMSEL_Z = 3'd5;
    // 3'd6 and 3'd7 are reserved and always decode as unsupported.

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purpose : combinational RISC-V immediate format mux (I/S/B/J/U and optional
//           CSR zimm). Every format is sign-extended from inst[31] to XLEN.
// Config  : IMMGEN_ZIMM_EN - when defined, select Z returns the zero-extended
//           zimm field inst[19:15]; otherwise Z is reported as unsupported.
// Ports   : inst [31:0]     instruction word (opcode bits [6:0] unused)
//           sel  [2:0]      format select (core_param::IMMSEL_*)
//           imm  [XLEN-1:0] generated immediate, zero when unsupported
//           err             select was unsupported
// -----------------------------------------------------------------------------
module imm_decode
    import core_param::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^inst[6:0];

    // Every format is first assembled as a 32-bit value whose bit 31 already
    // equals inst[31] (or 0 for zimm), so one signed cast widens all of them.
    always_comb begin
        imm32 = 32'd0;
        err   = 1'b0;
        case (sel)
            IMMSEL_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            IMMSEL_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMMSEL_B: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                               inst[30:25], inst[11:8], 1'b0};
            IMMSEL_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                               inst[20], inst[30:21], 1'b0};
            IMMSEL_U: imm32 = {inst[31:12], 12'd0};
`ifdef IMMGEN_ZIMM_EN
            IMMSEL_Z: imm32 = {27'd0, inst[19:15]};
`endif
            default:  err   = 1'b1;
        endcase
    end

    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
// Purpose : registered, valid/ready immediate generator for the decode stage.
//           A two-entry skid buffer (output register + skid register) keeps
//           decode back-pressure from forming a combinational path to fetch.
// Config  : IMMGEN_ZIMM_EN - enables the CSR zimm format (see imm_decode).
// Ports   : clk_i, rst_i (sync, active-high), flush_i (drop all entries)
//           in_valid_i / in_ready_o, inst_i, ImmSel_i, pass_i   (upstream)
//           out_valid_o / out_ready_i, imm_o, pass_o, imm_err_o (downstream)
// -----------------------------------------------------------------------------
module imm_gen_stage
    import core_param::*;
#(
    parameter int XLEN   = 32,
    parameter int PASS_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [2:0]        ImmSel_i,
    input  logic [PASS_W-1:0] pass_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   imm_o,
    output logic [PASS_W-1:0] pass_o,
    output logic              imm_err_o
);

    skid_state_t       state, state_next;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_err;
    logic [XLEN-1:0]   skid_imm;
    logic [PASS_W-1:0] skid_pass;
    logic              skid_err;
    logic              in_fire, out_fire;
    logic              out_load, out_from_skid, skid_load;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst (inst_i),
        .sel  (ImmSel_i),
        .imm  (dec_imm),
        .err  (dec_err)
    );

    // Both handshake outputs are pure functions of the state register, so
    // out_ready_i only ever reaches state_next.
    assign in_ready_o  = (state != ST_TWO);
    assign out_valid_o = (state != ST_EMPTY);
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides every transfer; an entry offered in that cycle is lost.
    always_comb begin
        state_next    = state;
        out_load      = 1'b0;
        out_from_skid = 1'b0;
        skid_load     = 1'b0;
        if (flush_i) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_ONE;
                        out_load   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_load = 1'b1;
                    end else if (in_fire) begin
                        state_next = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_next    = ST_ONE;
                        out_load      = 1'b1;
                        out_from_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Data registers only move on a load, so outputs hold under back-pressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imm_o     <= '0;
            pass_o    <= '0;
            imm_err_o <= 1'b0;
            skid_imm  <= '0;
            skid_pass <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (out_load) begin
                imm_o     <= out_from_skid ? skid_imm  : dec_imm;
                pass_o    <= out_from_skid ? skid_pass : pass_i;
                imm_err_o <= out_from_skid ? skid_err  : dec_err;
            end
            if (skid_load) begin
                skid_imm  <= dec_imm;
                skid_pass <= pass_i;
                skid_err  <= dec_err;
            end
        end
    end

endmodule
